dpwm_multi: RTL
===============

DPWM_MULTI -- requirements
Module: dpwm_multi

Interface
REQ-001 Parameter: WIDTH, 4, bit width of counter, period and each duty word.
REQ-002 Parameter: CHANNELS, 2, number of independent PWM outputs sharing one counter.
REQ-003 Parameter: CENTER, 0, 0 = edge-aligned, 1 = center-aligned counting.
REQ-004 Port: f_in  input  1  sole clock; all logic on rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: Per  input  WIDTH  period value P, sampled only at period boundary.
REQ-007 Port: Ref  input  CHANNELS*WIDTH  duty words; channel i at bits [i*WIDTH +: WIDTH].
REQ-008 Port: Ref_load  input  1  single-cycle pulse; captures Ref into pending registers.
REQ-009 Port: Ref_busy  output  1  high while a captured Ref has not yet been applied.
REQ-010 Port: Signal_o  output  CHANNELS  registered PWM outputs.
REQ-011 Port: Sync_o  output  1  one-cycle pulse on each period boundary cycle.

Function
REQ-012 Edge mode SHALL count 0,1,...,P-1 then wrap to 0; period = P cycles.
REQ-013 Center mode SHALL count up 0..P-1, then down P-1..0; period = 2P cycles; endpoint values appear twice.
REQ-014 Boundary SHALL be the cycle the counter is 0 at the start of an up phase (edge: every 0).
REQ-015 At boundary, active period SHALL load from Per, and active duties SHALL load from pending if Ref_busy.
REQ-016 Signal_o[i] SHALL equal (counter < active duty i) from the previous cycle (one-cycle registered latency).
REQ-017 Duty 0 SHALL give constant low; duty >= P SHALL give constant high, no glitch.
REQ-018 Edge mode high time SHALL be exactly d cycles per period; center mode 2d cycles, symmetric about the count peak.
REQ-019 Ref_load SHALL set Ref_busy on the next cycle; Ref_busy SHALL clear in the cycle after the applying boundary.
REQ-020 Ref_load while Ref_busy SHALL overwrite pending (last load wins); a single application follows.
REQ-021 Ref_load coincident with a boundary SHALL NOT apply that cycle; it applies at the following boundary.
REQ-022 P = 0 SHALL hold counter at 0, drive Signal_o low, and assert Sync_o every cycle.
REQ-023 Per change mid-period SHALL take effect only at the next boundary.
REQ-024 Counter and compare arithmetic SHALL be unsigned WIDTH bits, no overflow at P = 2^WIDTH-1.

Reset
REQ-025 rst SHALL clear counter, direction (up), active and pending duties, active period to 0.
REQ-026 During rst and the first cycle after, Signal_o SHALL be 0, Ref_busy 0, Sync_o 0.
REQ-027 rst mid-period SHALL discard pending Ref; first boundary is the first cycle after rst deasserts.

Structure
REQ-028 Package dpwm_pkg SHALL hold mode constants (EDGE, CENTER) and default WIDTH/CHANNELS values.
REQ-029 Shared counter and boundary logic SHALL live in dpwm_multi; per-channel pending/active registers and comparator SHALL be sub-module dpwm_channel, generated CHANNELS times.

Verification
REQ-030 WIDTH=4, CHANNELS=2, edge, Per=10, Ref={7,3} loaded -> ch0 high 3/10 cycles, ch1 high 7/10, Sync_o every 10 cycles.
REQ-031 Ref_load ch0=5 at counter 4 -> ch0 stays 3 until next boundary, then 5; Ref_busy high 6-7 cycles then low.
REQ-032 Ref ch0=0, ch1=12 with Per=10 -> ch0 constant low, ch1 constant high across 3 periods.
REQ-033 CENTER=1, Per=8, ch0 duty 4 -> period 16, ch0 high 8 cycles, low 8 cycles, symmetric about peak.
REQ-034 Two Ref_load pulses (2 then 6) in one period -> only 6 applied at boundary; Per changed 10->6 mid-period -> new length from next boundary.
REQ-035 rst asserted at counter 5 with pending load -> Signal_o 0, Ref_busy 0; after release outputs resume with duty 0.

Source files
------------

// File: rtl/dpwm_pkg.sv
// Shared constants and types for the multi-channel DPWM.
package dpwm_pkg;

    localparam int unsigned DEF_WIDTH    = 4;
    localparam int unsigned DEF_CHANNELS = 2;

    // Counting mode selectors for the CENTER parameter
    localparam int unsigned EDGE   = 0;
    localparam int unsigned CENTER = 1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/dpwm_channel.sv
// One PWM channel: pending/active duty registers and the registered comparator.
module dpwm_channel
    import dpwm_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             apply,
    input  logic [WIDTH-1:0] ref_word,
    input  logic [WIDTH-1:0] cnt,
    input  logic             run,
    output logic             pwm
);

    logic [WIDTH-1:0] pend_q;
    logic [WIDTH-1:0] act_q;
    logic [WIDTH-1:0] duty_eff;

    // A newly applied duty already governs the boundary cycle's compare
    assign duty_eff = apply ? pend_q : act_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            act_q  <= '0;
            pwm    <= 1'b0;
        end else begin
            if (load) begin
                pend_q <= ref_word;
            end
            act_q <= duty_eff;
            pwm   <= run && (cnt < duty_eff);
        end
    end

endmodule

// File: rtl/dpwm_multi.sv
// Multi-channel DPWM: one shared edge- or center-aligned counter, per-channel comparators.
module dpwm_multi
    import dpwm_pkg::DEF_WIDTH;
    import dpwm_pkg::DEF_CHANNELS;
    import dpwm_pkg::EDGE;
    import dpwm_pkg::dir_e;
    import dpwm_pkg::DIR_UP;
    import dpwm_pkg::DIR_DOWN;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned CHANNELS = DEF_CHANNELS,
    parameter int unsigned CENTER   = EDGE
) (
    input  logic                      f_in,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          Per,
    input  logic [CHANNELS*WIDTH-1:0] Ref,
    input  logic                      Ref_load,
    output logic                      Ref_busy,
    output logic [CHANNELS-1:0]       Signal_o,
    output logic                      Sync_o
);

    localparam bit IS_CENTER = (CENTER == dpwm_pkg::CENTER);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] per_q;
    logic [WIDTH-1:0] per_eff;
    dir_e             dir_q;
    dir_e             dir_d;
    logic             boundary;
    logic             apply;
    logic             run;

    // Boundary is count 0 at the start of an up phase; Per is taken only there
    assign boundary = (cnt_q == '0) && (dir_q == DIR_UP);
    assign per_eff  = boundary ? Per : per_q;
    assign apply    = boundary && Ref_busy;
    assign run      = (per_eff != '0);

    always_ff @(posedge f_in) begin
        if (rst) begin
            cnt_q    <= '0;
            dir_q    <= DIR_UP;
            per_q    <= '0;
            Ref_busy <= 1'b0;
            Sync_o   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            per_q    <= per_eff;
            Ref_busy <= Ref_load || (Ref_busy && !boundary);
            Sync_o   <= boundary;
        end
    end

    // Counter sequencing; endpoints repeat once in center mode
    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (!run) begin
            cnt_d = '0;
            dir_d = DIR_UP;
        end else if (!IS_CENTER) begin
            cnt_d = (cnt_q == per_eff - WIDTH'(1)) ? '0 : cnt_q + WIDTH'(1);
        end else if (dir_q == DIR_UP) begin
            if (cnt_q == per_eff - WIDTH'(1)) begin
                dir_d = DIR_DOWN;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end else begin
            if (cnt_q == '0) begin
                dir_d = DIR_UP;
            end else begin
                cnt_d = cnt_q - WIDTH'(1);
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        dpwm_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk      (f_in),
            .rst      (rst),
            .load     (Ref_load),
            .apply    (apply),
            .ref_word (Ref[i*WIDTH +: WIDTH]),
            .cnt      (cnt_q),
            .run      (run),
            .pwm      (Signal_o[i])
        );
    end

endmodule
